mem_boot_bridge: RTL and testbench

// - Sits between the RISC_Processor memory port (Address/D_out/D_in/mw_en) and the synchronous-write RAM.
// - After reset, a boot FSM loads a program from an upstream byte stream into RAM while holding the CPU in reset.
// - It then releases the CPU and becomes a pass-through bridge with one memory-mapped output register.

---
 rtl/mem_boot_bridge_pkg.sv | 23 ++
 rtl/mem_boot_bridge_boot_loader_fsm.sv | 119 +++++++++++
 rtl/mem_boot_bridge.sv | 81 ++++++++
 tb/tb_mem_boot_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_bridge_pkg.sv
// Shared definitions for the memory boot bridge.
// Holds boot FSM state encodings and default bridge parameters.
package mem_boot_bridge_pkg;

    localparam int          DEF_MEM_DEPTH = 256;
    localparam logic [15:0] DEF_IO_ADDR   = 16'hFFFF;

    typedef enum logic [2:0] {
        BS_LEN_HI,
        BS_LEN_LO,
        BS_DATA_HI,
        BS_DATA_LO,
        BS_WRITE,
        BS_RUN,
        BS_ERR
    } boot_state_t;

    // Width of a RAM word address for a given depth (at least 1 bit).
    function automatic int addr_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_boot_bridge_boot_loader_fsm.sv
// Boot loader: assembles length/data bytes, writes words into RAM,
// and holds the CPU in reset until the whole program is loaded.
// Ports: i_rx_* byte stream in, o_rx_ready, o_cpu_reset,
//        o_state, o_wr_en/o_wr_addr/o_wr_data (RAM write port).
module boot_loader_fsm
    import mem_boot_bridge_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_cpu_reset,
    output boot_state_t o_state,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic [15:0] o_wr_data
);

    localparam int AW = addr_bits(MEM_DEPTH);

    boot_state_t     r_state;
    boot_state_t     w_next;
    logic [7:0]      r_len_hi;
    logic [15:0]     r_len;
    logic [7:0]      r_data_hi;
    logic [15:0]     r_word;
    logic [AW-1:0]   r_load_addr;
    logic [15:0]     r_word_cnt;
    logic            r_cpu_reset;

    logic            w_rx_ready;
    logic            w_xfer;
    logic            w_we;
    logic [15:0]     w_len_rx;
    logic            w_last;

    assign w_xfer   = i_rx_valid & w_rx_ready;
    assign w_len_rx = {r_len_hi, i_rx_data};
    // r_len is at least 1 whenever WRITE is reached.
    assign w_last   = (r_word_cnt == (r_len - 16'd1));

    always_comb begin
        w_next     = r_state;
        w_rx_ready = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            BS_LEN_HI: begin
                w_rx_ready = 1'b1;
                if (w_xfer) w_next = BS_LEN_LO;
            end
            BS_LEN_LO: begin
                w_rx_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len_rx == 16'd0)
                        w_next = BS_RUN;
                    else if (32'(w_len_rx) > 32'(MEM_DEPTH))
                        w_next = BS_ERR;
                    else
                        w_next = BS_DATA_HI;
                end
            end
            BS_DATA_HI: begin
                w_rx_ready = 1'b1;
                if (w_xfer) w_next = BS_DATA_LO;
            end
            BS_DATA_LO: begin
                w_rx_ready = 1'b1;
                if (w_xfer) w_next = BS_WRITE;
            end
            BS_WRITE: begin
                w_we   = 1'b1;
                w_next = w_last ? BS_RUN : BS_DATA_HI;
            end
            BS_RUN:  w_next = BS_RUN;
            BS_ERR:  w_next = BS_ERR;
            default: w_next = BS_LEN_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= BS_LEN_HI;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_data_hi   <= '0;
            r_word      <= '0;
            r_load_addr <= '0;
            r_word_cnt  <= '0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state <= w_next;
            // Falls on the same edge that enters RUN.
            r_cpu_reset <= (w_next != BS_RUN);
            if (w_xfer && r_state == BS_LEN_HI)
                r_len_hi <= i_rx_data;
            if (w_xfer && r_state == BS_LEN_LO)
                r_len <= w_len_rx;
            if (w_xfer && r_state == BS_DATA_HI)
                r_data_hi <= i_rx_data;
            if (w_xfer && r_state == BS_DATA_LO)
                r_word <= {r_data_hi, i_rx_data};
            if (r_state == BS_WRITE) begin
                r_load_addr <= r_load_addr + 1'b1;
                r_word_cnt  <= r_word_cnt + 16'd1;
            end
        end
    end

    assign o_rx_ready  = w_rx_ready;
    assign o_cpu_reset = r_cpu_reset;
    assign o_state     = r_state;
    assign o_wr_en     = w_we;
    assign o_wr_addr   = 16'(r_load_addr);
    assign o_wr_data   = r_word;

endmodule

// File: rtl/mem_boot_bridge.sv
// Bridge between the CPU memory port and a sync-write RAM: boots RAM
// from a byte stream, then passes CPU accesses through with one MMIO reg.
// Ports: clk/reset, rx_* boot stream, cpu_* CPU side, ram_* RAM side,
//        io_out MMIO register, boot_done/boot_err status.
module mem_boot_bridge
    import mem_boot_bridge_pkg::*;
#(
    parameter int          MEM_DEPTH = DEF_MEM_DEPTH,
    parameter logic [15:0] IO_ADDR   = DEF_IO_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_reset,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_mw_en,
    output logic [15:0] cpu_din,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [15:0] io_out,
    output logic        boot_done,
    output logic        boot_err
);

    boot_state_t w_state;
    logic        w_wr_en;
    logic [15:0] w_wr_addr;
    logic [15:0] w_wr_data;
    logic        w_run;
    logic        w_io_hit;
    logic [15:0] r_io_out;

    boot_loader_fsm #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_boot (
        .clk         (clk),
        .reset       (reset),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_cpu_reset (cpu_reset),
        .o_state     (w_state),
        .o_wr_en     (w_wr_en),
        .o_wr_addr   (w_wr_addr),
        .o_wr_data   (w_wr_data)
    );

    assign w_run    = (w_state == BS_RUN);
    assign w_io_hit = (cpu_addr == IO_ADDR);

    // CPU side is ignored entirely until boot completes.
    always_comb begin
        ram_addr  = w_wr_addr;
        ram_wdata = w_wr_data;
        ram_we    = w_wr_en;
        cpu_din   = 16'h0000;
        if (w_run) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_dout;
            ram_we    = cpu_mw_en & ~w_io_hit;
            cpu_din   = w_io_hit ? r_io_out : ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_io_out <= 16'h0000;
        else if (w_run && cpu_mw_en && w_io_hit)
            r_io_out <= cpu_dout;
    end

    assign io_out    = r_io_out;
    assign boot_done = w_run;
    assign boot_err  = (w_state == BS_ERR);

endmodule

// File: tb/tb_mem_boot_bridge.sv
// Self-checking bench for mem_boot_bridge.
// Scoreboard of expected RAM writes plus directed RUN-mode checks.
module tb_mem_boot_bridge;

    localparam int          DEPTH = 256;
    localparam logic [15:0] IOA   = 16'hFFFF;
    localparam logic [15:0] SENT  = 16'hDEAD;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_reset;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_mw_en;
    logic [15:0] cpu_din;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] io_out;
    logic        boot_done;
    logic        boot_err;

    mem_boot_bridge #(
        .MEM_DEPTH (DEPTH),
        .IO_ADDR   (IOA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cpu_reset (cpu_reset),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_mw_en (cpu_mw_en),
        .cpu_din   (cpu_din),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .io_out    (io_out),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:DEPTH-1];
    logic        fill;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= SENT;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
    end

    assign ram_rdata = mem[ram_addr[7:0]];

    int          n_chk;
    int          n_pass;
    int          wr_pulses;
    logic        prev_we;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && cpu_reset && ram_we) begin
            wr_pulses++;
            chk("we_single", 32'(prev_we), 32'd0);
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("wr_data", {ram_addr, ram_wdata},
                    exp_q.pop_front());
        end
        prev_we = !reset && cpu_reset && ram_we;
    end

    task automatic do_fill();
        @(negedge clk);
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset     = 1'b0;
        wr_pulses = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_timeout", 32'(n), 32'd0);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n, input bit rnd);
        send_byte(n[15:8], rnd);
        send_byte(n[7:0], rnd);
    endtask

    task automatic send_word(input logic [15:0] w,
                             input logic [15:0] a,
                             input bit rnd);
        exp_q.push_back({a, w});
        send_byte(w[15:8], rnd);
        send_byte(w[7:0], rnd);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!boot_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(boot_done), 32'd1);
    endtask

    logic [15:0] words [3];

    initial begin
        words[0]  = 16'h1234;
        words[1]  = 16'hABCD;
        words[2]  = 16'h0001;
        n_chk     = 0;
        n_pass    = 0;
        wr_pulses = 0;
        prev_we   = 1'b0;
        fill      = 1'b0;
        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_dout  = 16'h0000;
        cpu_mw_en = 1'b0;
        #2 reset  = 1'b1;
        do_fill();
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(boot_done), 32'd0);
        chk("rst_err", 32'(boot_err), 32'd0);
        chk("rst_io_out", 32'(io_out), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_din", 32'(cpu_din), 32'd0);
        reset = 1'b0;

        // Back-to-back N=3 load while the CPU side tries an IO store.
        cpu_addr  = IOA;
        cpu_dout  = 16'h1111;
        cpu_mw_en = 1'b1;
        wr_pulses = 0;
        send_len(16'd3, 1'b0);
        send_word(words[0], 16'd0, 1'b0);
        send_word(words[1], 16'd1, 1'b0);
        send_word(words[2], 16'd2, 1'b0);
        #1;
        chk("t1_last_write", 32'(ram_we), 32'd1);
        chk("t1_rst_in_write", 32'(cpu_reset), 32'd1);
        chk("t1_din_boot", 32'(cpu_din), 32'd0);
        @(negedge clk);
        cpu_mw_en = 1'b0;
        chk("t1_done", 32'(boot_done), 32'd1);
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_io_ignored", 32'(io_out), 32'd0);
        chk("t1_pulses", 32'(wr_pulses), 32'd3);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_rx_ready_run", 32'(rx_ready), 32'd0);
        for (int i = 0; i < 3; i++)
            chk("t1_mem", 32'(mem[i]), 32'(words[i]));
        chk("t1_mem3", 32'(mem[3]), 32'(SENT));

        // RUN: IO store, IO read, RAM read, RAM store.
        cpu_addr  = IOA;
        cpu_dout  = 16'h00A5;
        cpu_mw_en = 1'b1;
        #1 chk("io_st_no_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        cpu_mw_en = 1'b0;
        cpu_dout  = 16'h0000;
        chk("io_out", 32'(io_out), 32'h00A5);
        #1 chk("io_rd", 32'(cpu_din), 32'h00A5);
        cpu_addr = 16'h0001;
        #1 chk("ram_rd1", 32'(cpu_din), 32'hABCD);
        @(negedge clk);
        cpu_addr  = 16'h0010;
        cpu_dout  = 16'h5555;
        cpu_mw_en = 1'b1;
        #1 chk("ram_st_we", 32'(ram_we), 32'd1);
        @(negedge clk);
        cpu_mw_en = 1'b0;
        cpu_dout  = 16'h0000;
        #1 chk("ram_rd10", 32'(cpu_din), 32'h5555);
        chk("io_kept", 32'(io_out), 32'h00A5);

        // N=0 goes straight to RUN.
        cpu_addr = 16'h0000;
        do_reset();
        chk("rst_io_clr", 32'(io_out), 32'd0);
        send_len(16'd0, 1'b0);
        chk("n0_done", 32'(boot_done), 32'd1);
        chk("n0_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("n0_pulses", 32'(wr_pulses), 32'd0);

        // N=MEM_DEPTH+1 is rejected.
        do_reset();
        send_len(16'(DEPTH + 1), 1'b0);
        chk("err_flag", 32'(boot_err), 32'd1);
        chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("err_rx_ready", 32'(rx_ready), 32'd0);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        chk("err_stays", 32'(boot_err), 32'd1);
        chk("err_done", 32'(boot_done), 32'd0);
        chk("err_pulses", 32'(wr_pulses), 32'd0);

        // Same N=3 load with random gaps on rx_valid.
        do_reset();
        do_fill();
        send_len(16'd3, 1'b1);
        send_word(words[0], 16'd0, 1'b1);
        send_word(words[1], 16'd1, 1'b1);
        send_word(words[2], 16'd2, 1'b1);
        wait_done("gap_done");
        chk("gap_pulses", 32'(wr_pulses), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("gap_mem", 32'(mem[i]), 32'(words[i]));

        // Reset in the middle of word 2, then a fresh N=1 load.
        do_reset();
        do_fill();
        send_len(16'd3, 1'b0);
        send_word(16'h1111, 16'd0, 1'b0);
        send_byte(8'h22, 1'b0);
        do_reset();
        chk("mid_rx_ready", 32'(rx_ready), 32'd1);
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_done", 32'(boot_done), 32'd0);
        do_fill();
        send_len(16'd1, 1'b0);
        send_word(16'h7777, 16'd0, 1'b0);
        wait_done("mid_new_done");
        chk("mid_pulses", 32'(wr_pulses), 32'd1);
        chk("mid_mem0", 32'(mem[0]), 32'h7777);
        chk("mid_mem1", 32'(mem[1]), 32'(SENT));

        // N=MEM_DEPTH fills the RAM exactly.
        do_reset();
        do_fill();
        send_len(16'(DEPTH), 1'b0);
        for (int i = 0; i < DEPTH; i++)
            send_word(16'(i) ^ 16'hA5C3, 16'(i), 1'b0);
        wait_done("full_done");
        chk("full_pulses", 32'(wr_pulses), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            chk("full_mem", 32'(mem[i]), 32'(16'(i) ^ 16'hA5C3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
